// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the round-robin arbiter and the UART TX core.
// The arbiter connects through the master modport; producers and the TX model use slave.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   i_req;
    logic [8*NUM_REQ-1:0] i_req_data;
    logic [NUM_REQ-1:0]   i_req_lock;
    logic [NUM_REQ-1:0]   o_grant;
    logic                 o_tx_dv;
    logic [7:0]           o_tx_byte;
    logic                 i_tx_active;
    logic                 i_tx_done;
    logic                 o_busy;
    logic [IDX_W-1:0]     o_last_idx;

    modport master (
        input  i_req, i_req_data, i_req_lock, i_tx_active, i_tx_done,
        output o_grant, o_tx_dv, o_tx_byte, o_busy, o_last_idx
    );

    modport slave (
        output i_req, i_req_data, i_req_lock, i_tx_active, i_tx_done,
        input  o_grant, o_tx_dv, o_tx_byte, o_busy, o_last_idx
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX among NUM_REQ byte producers.
// Optional macro TX_LOCK_EN: a requester granted with its lock hint set keeps priority.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             win_found;
    logic             arb_go;

`ifdef TX_LOCK_EN
    logic lock_q;
    logic lock_hit;
    // The lock holder is always the last winner, so last_q doubles as its index.
    assign lock_hit = lock_q && bus.i_req[last_q];
`else
    logic unused_lock;
    assign unused_lock = ^bus.i_req_lock;
`endif

    // Scan last+1 .. last (wrapping); first requester found wins.
    always_comb begin
        win_idx   = last_q;
        win_found = 1'b0;
        cand      = last_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
            if (!win_found && bus.i_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`ifdef TX_LOCK_EN
        if (lock_hit) win_idx = last_q;
`endif
    end

    assign arb_go = (state == IDLE) && !bus.i_tx_active && win_found;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            last_q         <= IDX_W'(NUM_REQ - 1);
            bus.o_grant    <= '0;
            bus.o_tx_dv    <= 1'b0;
            bus.o_tx_byte  <= 8'h00;
            bus.o_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.o_grant <= '0;
                    bus.o_tx_dv <= 1'b0;
                    if (arb_go) begin
                        bus.o_grant   <= NUM_REQ'(1) << win_idx;
                        bus.o_tx_dv   <= 1'b1;
                        bus.o_tx_byte <= bus.i_req_data[{win_idx, 3'b000} +: 8];
                        bus.o_busy    <= 1'b1;
                        last_q        <= win_idx;
                        state         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    bus.o_grant <= '0;
                    bus.o_tx_dv <= 1'b0;
                    state       <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.i_tx_done) begin
                        bus.o_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    bus.o_grant <= '0;
                    bus.o_tx_dv <= 1'b0;
                    bus.o_busy  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef TX_LOCK_EN
    // Lock follows the winner's hint; it also drops once the holder stops requesting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_q <= 1'b0;
        end else if (state == IDLE && !bus.i_tx_active) begin
            if (arb_go)
                lock_q <= bus.i_req_lock[win_idx];
            else if (!bus.i_req[last_q])
                lock_q <= 1'b0;
        end
    end
`endif

    assign bus.o_last_idx = last_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter among NUM_REQ byte producers.
- Each requester presents a byte with a level request; the arbiter picks one winner and issues a single-cycle launch to the UART TX.
- It then waits for the transmitter's done pulse before re-arbitrating.
- Sits between producer logic (e.g. echo path, status reporter) and the UART TX core.

Parameters:
NUM_REQ, 4, number of requesters (legal 2..8)
IDX_W, $clog2(NUM_REQ), width of requester index (derived localparam, not overridable)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_req  input  NUM_REQ  level request per requester, byte pending
i_req_data  input  8*NUM_REQ  requester k byte on bits [8k+7:8k]
i_req_lock  input  NUM_REQ  per-requester lock hint (used only with TX_LOCK_EN)
o_grant  output  NUM_REQ  one-hot, single-cycle pulse: byte of that requester accepted
o_tx_dv  output  1  single-cycle launch strobe to UART TX
o_tx_byte  output  8  byte to UART TX, valid while o_tx_dv high, held until next launch
i_tx_active  input  1  UART TX currently shifting
i_tx_done  input  1  UART TX single-cycle pulse at end of stop bit
o_busy  output  1  high whenever state is not IDLE
o_last_idx  output  IDX_W  index of most recent grant

Behaviour:
- Reset (async assert, sync release): state IDLE. o_grant=0, o_tx_dv=0, o_tx_byte=8'h00, o_busy=0. Last pointer = NUM_REQ-1, so requester 0 has first priority; o_last_idx therefore reads NUM_REQ-1.
- States: IDLE, LAUNCH, WAIT_DONE. All outputs are registered.
- IDLE:
  - Sample i_req only when i_tx_active=0 and |i_req=1.
  - Winner = first set bit scanning last+1, last+2, ... wrapping mod NUM_REQ, ending at last.
  - At that edge: capture the winner's byte into o_tx_byte, set o_grant[w], set o_tx_dv, update last=w, go to LAUNCH.
  - If i_tx_active=1, hold IDLE; requests stay pending and no grant is issued.
- LAUNCH (exactly 1 cycle): o_grant and o_tx_dv are high; next state WAIT_DONE, where both drop to 0.
- Latency: request sampled in IDLE at cycle T -> o_grant and o_tx_dv high in cycle T+1.
- WAIT_DONE: stay until i_tx_done=1, then go to IDLE. The earliest next grant is 2 cycles after the i_tx_done cycle.
- Requester contract:
  - Hold the byte stable and i_req high until granted.
  - After the grant cycle, either drop i_req or present the next byte; the arbiter does not sample again before IDLE.
  - Dropping i_req before a grant is legal; only the current-cycle value counts.
- i_tx_done while in IDLE or LAUNCH: ignored.
- i_tx_active rising during LAUNCH/WAIT_DONE: no effect; only i_tx_done ends the wait.
- Single requester: granted on every pass; the pointer still updates.
- Reset mid-operation (any state): all outputs clear immediately; the pointer returns to NUM_REQ-1. The in-flight UART frame is not tracked after reset.

Optional Feature:
Macro TX_LOCK_EN.
- Defined:
  - If the granted requester k had i_req_lock[k]=1 at its grant, the next arbitration gives k absolute priority as long as i_req[k]=1.
  - The lock clears when k is granted with i_req_lock[k]=0, or when i_req[k]=0 at an IDLE arbitration; normal round-robin then resumes from k+1.
  - Lets a producer send a multi-byte message without interleaving.
- Undefined: i_req_lock is ignored and the arbiter is pure round-robin; no lock register is instantiated.

Test Plan:
1. Reset, i_req=4'b0010, data1=8'h55 -> o_grant=4'b0010 and o_tx_dv=1 one cycle later, o_tx_byte=8'h55, o_busy=1 until the cycle after i_tx_done.
2. i_req=4'b1111 held, bytes 8'hA0..8'hA3, done pulse 20 cycles after each launch -> grants 0,1,2,3,0 with bytes A0,A1,A2,A3,A0.
3. i_tx_active=1 with i_req=4'b0001 -> no grant for 50 cycles; drop i_tx_active -> grant[0] on the next cycle.
4. Reset pulse during WAIT_DONE after a grant to 1; after release i_req=4'b1100 -> grant[2] first (pointer back to 3), o_last_idx=2.
5. i_tx_done pulsed in IDLE with i_req=0 -> no state change, o_busy stays 0, o_tx_dv stays 0.
6. i_req=4'b0011, i_req_lock[0]=1 for two grants then 0 -> with TX_LOCK_EN grants 0,0,0,1; without it grants 0,1,0,1.
